// File: rtl/enfasi_pkg.sv
// enfasi_pkg: shared types and constants for the enfasi front end.
//   Z_W        filter input sample width (signed Q0.10)
//   Q_W        filter output sample width (signed Q1.10)
//   CH_MAX_W   channel tag width, wide enough for up to 8 requesters
//   sched_state_t  scheduler FSM states
//   sched_tag_t    per-sample tag carried alongside the filter pipeline
package enfasi_pkg;

  localparam int unsigned Z_W      = 11;
  localparam int unsigned Q_W      = 12;
  localparam int unsigned CH_MAX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic                valid;
    logic [CH_MAX_W-1:0] ch;
    logic                last;
  } sched_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req        request vector
//   last_grant index granted most recently; search starts one above it
//   gnt        one-hot grant (all zero when no request)
//   idx        index of the granted requester
//   any        at least one request present
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(last_grant) + i) % N_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/enfasi_sched.sv
// enfasi_sched: round-robin frame scheduler sharing one enfasi filter.
//   req_valid/req_z/req_last  per-channel sample sources
//   req_ready                 one-hot accept strobe for the granted channel
//   f_z                       registered filter input
//   f_q                       filter output, LAT clocks after f_z
//   out_valid/out_q/out_ch/out_last  tagged filter output
//   err                       sticky gap error
//   gap_cnt                   8-bit saturating gap count (ENFASI_SCHED_ERR_EN only)
// Optional feature macro: ENFASI_SCHED_ERR_EN enables gap detection, err and gap_cnt.
module enfasi_sched
  import enfasi_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned LAT       = 7,
  parameter int unsigned FLUSH_LEN = 2,
  localparam int unsigned CH_W     = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0][Z_W-1:0] req_z,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [Z_W-1:0]            f_z,
  input  logic [Q_W-1:0]            f_q,
  output logic                      out_valid,
  output logic [Q_W-1:0]            out_q,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_last,
  output logic                      err
`ifdef ENFASI_SCHED_ERR_EN
  ,
  output logic [7:0]                gap_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FLUSH_LEN + 1);

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [CH_W-1:0]  g_q, g_d;
  logic [CH_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Z_W-1:0]   f_z_q, f_z_d;
  sched_tag_t       tag_d;
  // Stage 0 rides with f_z; stages 1..LAT form the latency-matching pipe,
  // so stage LAT lines up with f_q.
  sched_tag_t       tag_q [LAT+1];
  logic             out_valid_q;
  logic [Q_W-1:0]   out_q_q;
  logic [CH_W-1:0]  out_ch_q;
  logic             out_last_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [CH_W-1:0]  arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (CH_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .idx        (arb_idx),
    .any        (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    g_d          = g_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    f_z_d        = '0;
    tag_d        = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          ready_d = arb_gnt;
          g_d     = arb_idx;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        // A gap keeps the zero sample and invalid tag from the defaults.
        if (req_valid[g_q]) begin
          f_z_d       = req_z[g_q];
          tag_d.valid = 1'b1;
          tag_d.ch    = CH_MAX_W'(g_q);
          tag_d.last  = req_last[g_q];
          if (req_last[g_q]) begin
            ready_d = '0;
            cnt_d   = CNT_W'(FLUSH_LEN - 1);
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          last_grant_d = g_q;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= '0;
      g_q          <= '0;
      last_grant_q <= CH_W'(N_REQ - 1);
      cnt_q        <= '0;
      f_z_q        <= '0;
      for (int unsigned i = 0; i <= LAT; i++) tag_q[i] <= '0;
      out_valid_q  <= 1'b0;
      out_q_q      <= '0;
      out_ch_q     <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      g_q          <= g_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      f_z_q        <= f_z_d;
      tag_q[0]     <= tag_d;
      for (int unsigned i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
      out_valid_q  <= tag_q[LAT].valid;
      out_q_q      <= tag_q[LAT].valid ? f_q : '0;
      out_ch_q     <= tag_q[LAT].valid ? tag_q[LAT].ch[CH_W-1:0] : '0;
      out_last_q   <= tag_q[LAT].valid & tag_q[LAT].last;
    end
  end

  assign req_ready = ready_q;
  assign f_z       = f_z_q;
  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;

`ifdef ENFASI_SCHED_ERR_EN
  logic       gap;
  logic       err_q;
  logic [7:0] gap_cnt_q;

  assign gap = (state_q == S_STREAM) && !req_valid[g_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      gap_cnt_q <= '0;
    end else if (gap) begin
      err_q <= 1'b1;
      if (gap_cnt_q != '1) gap_cnt_q <= gap_cnt_q + 8'd1;
    end
  end

  assign err     = err_q;
  assign gap_cnt = gap_cnt_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_enfasi_sched.sv
module tb_enfasi_sched;

  localparam int N   = 2;
  localparam int N4  = 4;
  localparam int LAT = 7;

  typedef struct {
    logic [11:0] q;
    int          ch;
    logic        last;
    int          cyc;
  } exp_t;

  typedef struct {
    int   ch;
    logic last;
    int   cyc;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT with N_REQ=2 ----------------
  logic              v  [N];
  logic [10:0]       zz [N];
  logic              ll [N];
  logic [N-1:0]      req_valid, req_last, req_ready;
  logic [N-1:0][10:0] req_z;
  logic [10:0]       f_z;
  logic [11:0]       f_q;
  logic              out_valid, out_last, err;
  logic [11:0]       out_q;
  logic [0:0]        out_ch;
`ifdef ENFASI_SCHED_ERR_EN
  logic [7:0]        gap_cnt;
`endif

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_z     = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_last[i]  = ll[i];
      req_z[i]     = zz[i];
    end
  end

  enfasi_sched #(.N_REQ(N), .LAT(LAT), .FLUSH_LEN(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_z     (req_z),
    .req_last  (req_last),
    .req_ready (req_ready),
    .f_z       (f_z),
    .f_q       (f_q),
    .out_valid (out_valid),
    .out_q     (out_q),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .err       (err)
`ifdef ENFASI_SCHED_ERR_EN
    , .gap_cnt (gap_cnt)
`endif
  );

  // Filter stand-in: sign-extend and add 1, delayed LAT clocks.
  logic [11:0] fp [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) fp[i] <= '0;
    end else begin
      fp[0] <= {f_z[10], f_z} + 12'd1;
      for (int i = 1; i < LAT; i++) fp[i] <= fp[i-1];
    end
  end
  assign f_q = fp[LAT-1];

  // ---------------- DUT with N_REQ=4 ----------------
  logic [N4-1:0]       v4, last4, ready4;
  logic [N4-1:0][10:0] z4;
  logic [10:0]         f_z4;
  logic [11:0]         f_q4, out_q4;
  logic                out_valid4, out_last4, err4;
  logic [1:0]          out_ch4;
`ifdef ENFASI_SCHED_ERR_EN
  logic [7:0]          gap_cnt4;
`endif

  enfasi_sched #(.N_REQ(N4), .LAT(LAT), .FLUSH_LEN(2)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v4),
    .req_z     (z4),
    .req_last  (last4),
    .req_ready (ready4),
    .f_z       (f_z4),
    .f_q       (f_q4),
    .out_valid (out_valid4),
    .out_q     (out_q4),
    .out_ch    (out_ch4),
    .out_last  (out_last4),
    .err       (err4)
`ifdef ENFASI_SCHED_ERR_EN
    , .gap_cnt (gap_cnt4)
`endif
  );

  logic [11:0] fp4 [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) fp4[i] <= '0;
    end else begin
      fp4[0] <= {f_z4[10], f_z4} + 12'd1;
      for (int i = 1; i < LAT; i++) fp4[i] <= fp4[i-1];
    end
  end
  assign f_q4 = fp4[LAT-1];

  // ---------------- checking ----------------
  exp_t sb[$];
  exp_t sb4[$];
  acc_t alog[$];
  int   glog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(out_q), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("out_q",    32'(out_q),    32'(mon_e.q));
        chk("out_ch",   32'(out_ch),   32'(mon_e.ch));
        chk("out_last", 32'(out_last), 32'(mon_e.last));
        chk("out_lat",  32'(cyc),      32'(mon_e.cyc));
      end
    end
  end

  exp_t mon_e4;
  always @(negedge clk) begin
    if (rst_n && out_valid4) begin
      if (sb4.size() == 0) begin
        chk("unexpected_out4", 32'(out_q4), 32'hFFFF_FFFF);
      end else begin
        mon_e4 = sb4.pop_front();
        chk("out_q4",    32'(out_q4),    32'(mon_e4.q));
        chk("out_ch4",   32'(out_ch4),   32'(mon_e4.ch));
        chk("out_last4", 32'(out_last4), 32'(mon_e4.last));
        chk("out_lat4",  32'(cyc),       32'(mon_e4.cyc));
      end
    end
  end

  logic [N-1:0] prev_ready = '0;
  always @(negedge clk) begin
    if (rst_n && req_ready != '0 && req_ready != prev_ready)
      for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
    prev_ready = req_ready;
  end

  // Drive one beat from a negedge and wait for its acceptance; returns at the
  // negedge after the accepting edge.
  task automatic beat(input int ch, input logic [10:0] z, input logic last);
    exp_t e;
    acc_t a;
    int   t;
    t      = 0;
    v[ch]  = 1'b1;
    zz[ch] = z;
    ll[ch] = last;
    while (!req_ready[ch]) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        chk("accept_timeout", 32'(ch), 32'hFFFF_FFFF);
        return;
      end
    end
    e.q    = {z[10], z} + 12'd1;
    e.ch   = ch;
    e.last = last;
    e.cyc  = cyc + LAT + 2;
    sb.push_back(e);
    a.ch   = ch;
    a.last = last;
    a.cyc  = cyc;
    alog.push_back(a);
    @(negedge clk);
  endtask

  task automatic frame2(input int ch, input logic [10:0] a, input logic [10:0] b);
    beat(ch, a, 1'b0);
    beat(ch, b, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  int cnt4;
  int bad4;
  exp_t e4;
  int exp_ch_seq [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; zz[i] = '0; ll[i] = 1'b0;
    end
    v4 = '0; last4 = '1; z4 = {N4{11'h123}};
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_q",     32'(out_q),     0);
    chk("rst_out_ch",    32'(out_ch),    0);
    chk("rst_out_last",  32'(out_last),  0);
    chk("rst_f_z",       32'(f_z),       0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_err",       32'(err),       0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame on ch0
    beat(0, 11'h080, 1'b0);
    beat(0, 11'h100, 1'b0);
    beat(0, 11'h180, 1'b1);
    v[0] = 1'b0;
    chk("t1_fz_hold", 32'(f_z), 32'h180);
    @(negedge clk);
    chk("t1_fz_flush1", 32'(f_z), 0);
    chk("t1_ready_flush1", 32'(req_ready), 0);
    @(negedge clk);
    chk("t1_fz_flush2", 32'(f_z), 0);
    repeat (12) @(negedge clk);

    // Flush check on ch1 (leaves last_grant at 1)
    beat(1, 11'h300, 1'b0);
    beat(1, 11'h380, 1'b1);
    v[1] = 1'b0;
    chk("fl_fz_hold", 32'(f_z), 32'h380);
    @(negedge clk);
    chk("fl_fz_flush1", 32'(f_z), 0);
    @(negedge clk);
    chk("fl_fz_flush2", 32'(f_z), 0);
    repeat (12) @(negedge clk);

    // Both channels, two 2-sample frames each
    alog.delete();
    glog.delete();
    fork
      begin
        frame2(0, 11'h011, 11'h012);
        frame2(0, 11'h013, 11'h014);
        v[0] = 1'b0;
      end
      begin
        frame2(1, 11'h021, 11'h022);
        frame2(1, 11'h023, 11'h024);
        v[1] = 1'b0;
      end
    join
    chk("rr_grant_count", 32'(glog.size()), 4);
    for (int i = 0; i < glog.size() && i < 4; i++)
      chk("rr_grant_order", 32'(glog[i]), 32'(i % 2));
    chk("rr_accept_count", 32'(alog.size()), 8);
    for (int i = 0; i < alog.size() && i < 8; i++)
      chk("rr_frame_ch", 32'(alog[i].ch), 32'(exp_ch_seq[i]));
    for (int i = 1; i < alog.size(); i++)
      chk("rr_accept_spacing", 32'(alog[i].cyc - alog[i-1].cyc), alog[i-1].last ? 32'd4 : 32'd1);
    repeat (12) @(negedge clk);
    chk("pre_gap_err", 32'(err), 0);

    // Gap on ch0 mid-frame
    beat(0, 11'h040, 1'b0);
    v[0] = 1'b0;
    @(negedge clk);
    chk("gap_fz", 32'(f_z), 0);
    chk("gap_ready", 32'(req_ready), 32'b01);
`ifdef ENFASI_SCHED_ERR_EN
    chk("gap_err", 32'(err), 1);
    chk("gap_cnt", 32'(gap_cnt), 1);
`else
    chk("gap_err", 32'(err), 0);
`endif
    beat(0, 11'h041, 1'b1);
    v[0] = 1'b0;
    repeat (12) @(negedge clk);
`ifdef ENFASI_SCHED_ERR_EN
    chk("err_sticky", 32'(err), 1);
`endif

    // Reset three beats into a ch1 frame
    beat(1, 11'h200, 1'b0);
    beat(1, 11'h201, 1'b0);
    beat(1, 11'h202, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_f_z",       32'(f_z),       0);
    chk("mrst_req_ready", 32'(req_ready), 0);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_out_q",     32'(out_q),     0);
    chk("mrst_err",       32'(err),       0);
    sb.delete();
    v[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    glog.delete();
    fork
      begin beat(0, 11'h055, 1'b1); v[0] = 1'b0; end
      begin beat(1, 11'h066, 1'b1); v[1] = 1'b0; end
    join
    chk("post_rst_grants", 32'(glog.size()), 2);
    if (glog.size() >= 2) begin
      chk("post_rst_first", 32'(glog[0]), 0);
      chk("post_rst_second", 32'(glog[1]), 1);
    end
    repeat (12) @(negedge clk);

    // N_REQ=4, only ch3 requesting single-sample frames
    cnt4 = 0;
    bad4 = 0;
    v4   = 4'b1000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ready4[3]) begin
        e4.q    = {1'b0, 11'h123} + 12'd1;
        e4.ch   = 3;
        e4.last = 1'b1;
        e4.cyc  = cyc + LAT + 2;
        sb4.push_back(e4);
        cnt4++;
      end
      if (ready4[2:0] != 3'b000) bad4++;
    end
    v4 = '0;
    chk("n4_accepts", 32'(cnt4), 4);
    chk("n4_other_ready", 32'(bad4), 0);

    repeat (15) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    chk("sb4_drained", 32'(sb4.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
